// File: rtl/dnn_pkg.sv
// rtl/dnn_pkg.sv - shared types and helpers for the DNN layer sequencer
package dnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        EMIT  = 2'd3
    } state_t;

    localparam int VEC_MAX_W   = 1024;
    localparam int SLICE_MAX_W = 128;

    // Activation slice k (4 elements of in_w bits), zero-padded to SLICE_MAX_W.
    function automatic logic [SLICE_MAX_W-1:0] chunk_sel(input logic [VEC_MAX_W-1:0] vec,
                                                         input int k, input int in_w);
        return SLICE_MAX_W'(vec >> (k * 4 * in_w));
    endfunction

    // Accumulator width: enough headroom to add C MAC results without overflow.
    function automatic int acc_width(input int mac_w, input int chunks);
        return (chunks > 1) ? mac_w + $clog2(chunks) : mac_w;
    endfunction

endpackage

// File: rtl/dnn_seq_pipe.sv
// rtl/dnn_seq_pipe.sv - stage B/C valid tracking and per-neuron accumulator
module dnn_seq_pipe
    import dnn_pkg::*;
#(
    parameter int CW    = 1,
    parameter int MAC_W = 12,
    parameter int ACC_W = 13
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue,
    input  logic [CW-1:0]           issue_chunk,
    input  logic                    issue_last,
    input  logic                    clear_acc,
    input  logic [MAC_W-1:0]        mac_result,
    input  logic                    mac_result_ready,
    output logic                    b_valid,
    output logic [CW-1:0]           b_chunk,
    output logic                    sum_valid,
    output logic signed [ACC_W-1:0] sum
);

    logic                    b_last;
    logic                    c_valid;
    logic                    c_last;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] res_ext;

    assign res_ext   = ACC_W'($signed(mac_result));
    assign sum       = acc + res_ext;
    assign sum_valid = c_valid && c_last;

    // The neuron's ready flag holds between bursts, so our own valids decide when to sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid <= 1'b0;
            b_chunk <= '0;
            b_last  <= 1'b0;
            c_valid <= 1'b0;
            c_last  <= 1'b0;
            acc     <= '0;
        end else begin
            b_valid <= issue;
            b_chunk <= issue_chunk;
            b_last  <= issue_last;
            c_valid <= b_valid;
            c_last  <= b_valid && b_last;
            if (clear_acc) begin
                acc <= '0;
            end else if (c_valid) begin
                acc <= sum;
            end
        end
    end

    a_result_ready: assert property (@(posedge clk) disable iff (!rst_n) c_valid |-> mac_result_ready);

endmodule

// File: rtl/dnn_layer_sequencer.sv
// rtl/dnn_layer_sequencer.sv - sequences one FC layer onto a shared 4-input MAC neuron
module dnn_layer_sequencer
    import dnn_pkg::*;
#(
    parameter int NUM_IN      = 8,
    parameter int NUM_NEURONS = 4,
    parameter int IN_W        = 5,
    parameter int W_W         = 5,
    parameter int MAC_W       = 12,
    parameter int ACC_W       = acc_width(MAC_W, NUM_IN / 4),
    parameter int RELU        = 1,
    localparam int C          = NUM_IN / 4,
    localparam int AW         = (NUM_NEURONS * C > 1) ? $clog2(NUM_NEURONS * C) : 1,
    localparam int IDXW       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_IN*IN_W-1:0] in_vec,
    output logic [AW-1:0]          w_addr,
    input  logic [4*W_W-1:0]       w_rdata,
    output logic                   mac_valid,
    output logic [4*IN_W-1:0]      mac_in,
    output logic [4*W_W-1:0]       mac_w,
    input  logic [MAC_W-1:0]       mac_result,
    input  logic                   mac_result_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDXW-1:0]        out_idx,
    output logic [ACC_W-1:0]       out_data,
    output logic                   busy,
    output logic                   done
);

    localparam int CW      = (C > 1) ? $clog2(C) : 1;
    localparam int SLICE_W = 4 * IN_W;

    state_t                   state, state_nx;
    logic [NUM_IN*IN_W-1:0]   act;
    logic [CW-1:0]            chunk;
    logic [IDXW-1:0]          neuron;
    logic                     issue, issue_last, accept, last_neuron, start_acc, clear_acc;
    logic                     b_valid;
    logic [CW-1:0]            b_chunk;
    logic                     sum_valid;
    logic signed [ACC_W-1:0]  sum;

    assign issue       = (state == RUN);
    assign issue_last  = issue && (chunk == CW'(C - 1));
    assign accept      = (state == EMIT) && out_ready;
    assign last_neuron = (neuron == IDXW'(NUM_NEURONS - 1));
    assign start_acc   = (state == IDLE) && start;
    assign clear_acc   = start_acc || (accept && !last_neuron);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (issue_last) state_nx = DRAIN;
            DRAIN:   if (sum_valid) state_nx = EMIT;
            EMIT:    if (out_ready) state_nx = last_neuron ? IDLE : RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        out_valid = (state == EMIT);
        out_idx   = out_valid ? neuron : '0;
        w_addr    = issue ? (AW'(neuron) * AW'(C) + AW'(chunk)) : '0;
        mac_valid = b_valid;
        mac_in    = b_valid ? SLICE_W'(chunk_sel(VEC_MAX_W'(act), int'(b_chunk), IN_W)) : '0;
        mac_w     = b_valid ? w_rdata : '0;
    end

    // The last chunk's sum bypasses the accumulator and lands directly in out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act      <= '0;
            chunk    <= '0;
            neuron   <= '0;
            out_data <= '0;
            done     <= 1'b0;
        end else begin
            done <= accept && last_neuron;
            if (start_acc) begin
                act    <= in_vec;
                neuron <= '0;
                chunk  <= '0;
            end
            if (issue) begin
                chunk <= issue_last ? '0 : chunk + CW'(1);
            end
            if (accept && !last_neuron) begin
                neuron <= neuron + IDXW'(1);
            end
            if (sum_valid) begin
                out_data <= (RELU != 0 && sum[ACC_W-1]) ? '0 : sum;
            end
        end
    end

    dnn_seq_pipe #(
        .CW    (CW),
        .MAC_W (MAC_W),
        .ACC_W (ACC_W)
    ) u_pipe (
        .clk              (clk),
        .rst_n            (rst_n),
        .issue            (issue),
        .issue_chunk      (chunk),
        .issue_last       (issue_last),
        .clear_acc        (clear_acc),
        .mac_result       (mac_result),
        .mac_result_ready (mac_result_ready),
        .b_valid          (b_valid),
        .b_chunk          (b_chunk),
        .sum_valid        (sum_valid),
        .sum              (sum)
    );

endmodule
